// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the run scheduler that owns the 10-bit up/down
// counter: FSM state encoding, direction constants, default widths and a
// small helper that turns a 2-way one-hot grant into a requester index.
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int CNT_W_DEF  = 10;
  localparam int STEP_W_DEF = 10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  // A 2-way grant is one-hot or zero, so bit 1 alone names the winner.
  function automatic logic grant_to_id(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the one that was not granted last wins. The "last granted"
// pointer only moves when the caller reports an accepted grant.
//
// Ports
//   i_clk      clock, all logic on posedge
//   i_rst_n    asynchronous active-low reset; pointer then favours req0
//   i_req      per-requester request
//   i_advance  grant was taken this cycle; update the pointer
//   o_grant    one-hot or zero grant, combinational from i_req
// ---------------------------------------------------------------------------
module rr_arb2
  import counter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // 1 means requester 1 was granted last, so requester 0 wins a tie.
  logic r_last_id;

  // Grant selection: a tie goes to whichever requester did not win last.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_id ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Pointer update. Reset value 1 makes req0 the first tie winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_id <= 1'b1;
    end else if (i_advance && (o_grant != 2'b00)) begin
      r_last_id <= grant_to_id(o_grant);
    end
  end

endmodule

// File: rtl/counter_run_sched.sv
// ---------------------------------------------------------------------------
// counter_run_sched
// Schedules the shared up/down counter between two requesters. Each
// accepted request is a "run": an optional one-cycle clear followed by N
// enable cycles in one direction. When the run ends (normally or by abort)
// a one-cycle done pulse reports the owner and the final counter value.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    per-requester request valid
//   o_req_ready    per-requester accept, one-hot or zero, only in IDLE
//   i_req_dir      per-requester direction (0 = up, 1 = down)
//   i_req_clr      per-requester: clear counter before the run
//   i_req_steps    per-requester step count, [STEP_W-1:0] is requester 0
//   i_abort        end the current run early (CLEAR/RUN only)
//   o_cnt_clr      synchronous clear to the counter
//   o_cnt_en       count enable to the counter
//   o_cnt_mode     direction to the counter, latched dir while busy
//   i_cnt_value    counter output
//   o_done_valid   one-cycle completion pulse
//   o_done_id      requester that owned the finished run
//   o_done_abort   run ended by abort
//   o_done_value   counter value at completion
//   o_busy         high in any state other than IDLE
// ---------------------------------------------------------------------------
module counter_run_sched
  import counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [1:0]          i_req_dir,
  input  logic [1:0]          i_req_clr,
  input  logic [2*STEP_W-1:0] i_req_steps,
  input  logic                i_abort,
  output logic                o_cnt_clr,
  output logic                o_cnt_en,
  output logic                o_cnt_mode,
  input  logic [CNT_W-1:0]    i_cnt_value,
  output logic                o_done_valid,
  output logic                o_done_id,
  output logic                o_done_abort,
  output logic [CNT_W-1:0]    o_done_value,
  output logic                o_busy
);

  run_state_e r_state;
  run_state_e w_next_state;

  // Latched request fields for the run in progress.
  logic              r_dir;
  logic              r_id;
  logic              r_abort;
  logic [STEP_W-1:0] r_remaining;

  // Completion report, held between done pulses.
  logic              r_done_id;
  logic              r_done_abort;
  logic [CNT_W-1:0]  r_done_value;

  logic [1:0]        w_arb_req;
  logic [1:0]        w_grant;
  logic              w_transfer;
  logic              w_win_id;
  logic              w_win_dir;
  logic              w_win_clr;
  logic [STEP_W-1:0] w_win_steps;
  logic              w_abort_take;
  logic              w_step_take;

  // Requests are only offered to the arbiter in IDLE, so a grant (and hence
  // req_ready) can never appear while a run is in flight.
  assign w_arb_req = (r_state == ST_IDLE) ? i_req_valid : 2'b00;

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (w_arb_req),
    .i_advance (w_transfer),
    .o_grant   (w_grant)
  );

  assign o_req_ready = w_grant;
  assign w_transfer  = |(w_grant & i_req_valid);
  assign w_win_id    = grant_to_id(w_grant);
  assign w_win_dir   = i_req_dir[w_win_id];
  assign w_win_clr   = i_req_clr[w_win_id];
  assign w_win_steps = w_win_id ? i_req_steps[2*STEP_W-1:STEP_W]
                                : i_req_steps[STEP_W-1:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and counter controls. Abort wins over clr/en in the same
  // cycle so the counter sees no further update once abort is raised.
  always_comb begin
    w_next_state = r_state;
    o_cnt_clr    = 1'b0;
    o_cnt_en     = 1'b0;
    w_abort_take = 1'b0;
    w_step_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_transfer) begin
          if (w_win_clr) begin
            w_next_state = ST_CLEAR;
          end else if (w_win_steps == '0) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RUN;
          end
        end
      end
      ST_CLEAR: begin
        if (i_abort) begin
          w_abort_take = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          o_cnt_clr    = 1'b1;
          w_next_state = (r_remaining == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // r_remaining is never zero here: zero-step runs bypass RUN.
        if (i_abort) begin
          w_abort_take = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          o_cnt_en    = 1'b1;
          w_step_take = 1'b1;
          if (r_remaining == STEP_W'(1)) begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Status and completion outputs. During DONE the report is taken live so
  // done_value shows the counter after its last update; afterwards the held
  // copy keeps the report stable until the next run completes.
  always_comb begin
    o_busy       = (r_state != ST_IDLE);
    o_cnt_mode   = o_busy ? r_dir : DIR_UP;
    o_done_valid = (r_state == ST_DONE);
    o_done_id    = r_done_id;
    o_done_abort = r_done_abort;
    o_done_value = r_done_value;
    if (r_state == ST_DONE) begin
      o_done_id    = r_id;
      o_done_abort = r_abort;
      o_done_value = i_cnt_value;
    end
  end

  // Run bookkeeping: latch the winner's request on transfer, count down the
  // remaining enables, remember an abort, and snapshot the report in DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir        <= DIR_UP;
      r_id         <= 1'b0;
      r_abort      <= 1'b0;
      r_remaining  <= '0;
      r_done_id    <= 1'b0;
      r_done_abort <= 1'b0;
      r_done_value <= '0;
    end else begin
      if (w_transfer) begin
        r_dir       <= w_win_dir;
        r_id        <= w_win_id;
        r_remaining <= w_win_steps;
        r_abort     <= 1'b0;
      end
      if (w_step_take) begin
        r_remaining <= r_remaining - STEP_W'(1);
      end
      if (w_abort_take) begin
        r_abort <= 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_done_id    <= r_id;
        r_done_abort <= r_abort;
        r_done_value <= i_cnt_value;
      end
    end
  end

endmodule

// File: tb/tb_counter_run_sched.sv
// ---------------------------------------------------------------------------
// tb_counter_run_sched
// Self-checking bench for counter_run_sched. A simple 10-bit up/down counter
// lives here as the environment. Expected results come from the run rules:
// final value = (clear ? 0 : start) +/- enables mod 2^10, enables = N (or
// abort position - 1), done latency = clear + enables + 1 (+1 on abort),
// and tie winner = requester not granted last.
// ---------------------------------------------------------------------------
module tb_counter_run_sched;

  localparam int CNT_W  = 10;
  localparam int STEP_W = 10;

  logic                clk = 1'b0;
  logic                rstN;
  logic [1:0]          reqValid;
  logic [1:0]          reqReady;
  logic [1:0]          reqDir;
  logic [1:0]          reqClr;
  logic [2*STEP_W-1:0] reqSteps;
  logic                abortIn;
  logic                cntClr;
  logic                cntEn;
  logic                cntMode;
  logic [CNT_W-1:0]    cntValue;
  logic                doneValid;
  logic                doneId;
  logic                doneAbort;
  logic [CNT_W-1:0]    doneValue;
  logic                busy;

  logic                loadEn;
  logic [CNT_W-1:0]    loadVal;

  int checks    = 0;
  int failures  = 0;
  int enCount   = 0;
  int clrCount  = 0;
  int doneCount = 0;
  int bothReady = 0;
  int modeErr   = 0;
  logic expDir  = 1'b0;
  int lastGrant = 1;

  always #5 clk = ~clk;

  counter_run_sched #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_dir    (reqDir),
    .i_req_clr    (reqClr),
    .i_req_steps  (reqSteps),
    .i_abort      (abortIn),
    .o_cnt_clr    (cntClr),
    .o_cnt_en     (cntEn),
    .o_cnt_mode   (cntMode),
    .i_cnt_value  (cntValue),
    .o_done_valid (doneValid),
    .o_done_id    (doneId),
    .o_done_abort (doneAbort),
    .o_done_value (doneValue),
    .o_busy       (busy)
  );

  // Environment counter; the bench can preload it between runs.
  always @(posedge clk) begin
    if (loadEn) cntValue <= loadVal;
    else if (cntClr) cntValue <= '0;
    else if (cntEn) cntValue <= cntMode ? cntValue - 1'b1 : cntValue + 1'b1;
  end

  // Activity monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (cntEn === 1'b1) enCount++;
    if (cntClr === 1'b1) clrCount++;
    if (doneValid === 1'b1) doneCount++;
    if (reqReady === 2'b11) bothReady++;
    if (cntMode !== (busy === 1'b1 ? expDir : 1'b0)) modeErr++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One complete run with its own expectations derived from the run rules.
  task automatic runOne(input string name, input int id, input logic dir, input logic clr,
                        input int steps, input int abortAt, input logic [CNT_W-1:0] startVal);
    bit accepted;
    bit finished;
    int k;
    int expEn;
    int expLat;
    int enBase, clrBase, doneBase, modeBase;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] expVal;
    @(negedge clk);
    loadVal = startVal;
    loadEn  = 1'b1;
    @(negedge clk);
    loadEn   = 1'b0;
    expDir   = dir;
    enBase   = enCount;
    clrBase  = clrCount;
    doneBase = doneCount;
    modeBase = modeErr;
    reqDir[id] = dir;
    reqClr[id] = clr;
    reqSteps[id*STEP_W +: STEP_W] = STEP_W'(steps);
    reqValid[id] = 1'b1;
    accepted = 0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (reqReady[id] === 1'b1) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!accepted) begin
      failures++;
      $display("[TB] FAIL %s accept: ready never seen for req%0d", name, id);
      reqValid[id] = 1'b0;
      return;
    end
    lastGrant = id;
    finished = 0;
    k = 0;
    while (!finished && k < steps + 12) begin
      @(negedge clk);
      k++;
      if (k == 1) reqValid[id] = 1'b0;
      abortIn = (abortAt > 0) && (k == abortAt + int'(clr));
      #1;
      if (doneValid === 1'b1) finished = 1;
    end
    abortIn = 1'b0;
    expEn  = (abortAt > 0) ? abortAt - 1 : steps;
    expLat = int'(clr) + expEn + 1 + ((abortAt > 0) ? 1 : 0);
    base   = clr ? '0 : startVal;
    expVal = dir ? base - CNT_W'(expEn) : base + CNT_W'(expEn);
    checks++;
    if (!finished) begin
      failures++;
      $display("[TB] FAIL %s done: no done pulse within %0d cycles", name, k);
    end
    checks++;
    if (k != expLat) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, k, expLat);
    end
    checks++;
    if (doneId !== id[0]) begin
      failures++;
      $display("[TB] FAIL %s doneId: got %0d, expected %0d", name, doneId, id);
    end
    checks++;
    if (doneAbort !== (abortAt > 0)) begin
      failures++;
      $display("[TB] FAIL %s doneAbort: got %0d, expected %0d", name, doneAbort, abortAt > 0);
    end
    checks++;
    if (doneValue !== expVal) begin
      failures++;
      $display("[TB] FAIL %s doneValue: got %h, expected %h", name, doneValue, expVal);
    end
    @(negedge clk);
    #2;
    checks++;
    if (enCount - enBase != expEn) begin
      failures++;
      $display("[TB] FAIL %s enables: got %0d, expected %0d", name, enCount - enBase, expEn);
    end
    checks++;
    if (clrCount - clrBase != int'(clr)) begin
      failures++;
      $display("[TB] FAIL %s clears: got %0d, expected %0d", name, clrCount - clrBase, clr);
    end
    checks++;
    if (doneCount - doneBase != 1) begin
      failures++;
      $display("[TB] FAIL %s donePulses: got %0d, expected 1", name, doneCount - doneBase);
    end
    checks++;
    if (busy !== 1'b0 || doneValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s afterDone: busy=%0d doneValid=%0d, expected 0/0", name, busy, doneValid);
    end
    checks++;
    if (doneValue !== expVal) begin
      failures++;
      $display("[TB] FAIL %s doneHold: got %h, expected %h", name, doneValue, expVal);
    end
    checks++;
    if (modeErr - modeBase != 0) begin
      failures++;
      $display("[TB] FAIL %s cntMode: %0d bad cycles, expected 0", name, modeErr - modeBase);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (reqReady !== 2'b00) begin failures++; $display("[TB] FAIL reset reqReady: got %b, expected 00", reqReady); end
    checks++;
    if (cntEn !== 1'b0 || cntClr !== 1'b0) begin failures++; $display("[TB] FAIL reset cntEn/cntClr: got %0d/%0d, expected 0/0", cntEn, cntClr); end
    checks++;
    if (cntMode !== 1'b0) begin failures++; $display("[TB] FAIL reset cntMode: got %0d, expected 0", cntMode); end
    checks++;
    if (doneValid !== 1'b0 || doneId !== 1'b0 || doneAbort !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset done flags: got %0d/%0d/%0d, expected 0/0/0", doneValid, doneId, doneAbort);
    end
    checks++;
    if (doneValue !== '0) begin failures++; $display("[TB] FAIL reset doneValue: got %h, expected 000", doneValue); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %0d, expected 0", busy); end
    @(negedge clk);
    rstN = 1'b1;
    lastGrant = 1;
  endtask

  task automatic test_clear_runs();
    runOne("clear_up", 0, 1'b0, 1'b1, 5, 0, 10'h3F3);
    runOne("clear_down_wrap", 1, 1'b1, 1'b1, 3, 0, 10'h155);
  endtask

  task automatic test_back_to_back();
    int rem0, rem1, grants, expWin, doneBase, bothBase;
    @(negedge clk);
    rstN = 1'b0;
    reqValid = 2'b00;
    @(negedge clk);
    rstN = 1'b1;
    lastGrant = 1;
    rem0 = 2;
    rem1 = 1;
    grants = 0;
    reqSteps = {10'd2, 10'd2};
    reqDir = 2'b00;
    reqClr = 2'b00;
    expDir = 1'b0;
    doneBase = doneCount;
    bothBase = bothReady;
    for (int c = 0; c < 200 && (rem0 + rem1) > 0; c++) begin
      @(negedge clk);
      reqValid = {rem1 > 0, rem0 > 0};
      #1;
      if (reqReady !== 2'b00) begin
        expWin = (reqValid == 2'b11) ? ((lastGrant == 0) ? 1 : 0) : (reqValid[1] ? 1 : 0);
        checks++;
        if (reqReady !== (2'b01 << expWin)) begin
          failures++;
          $display("[TB] FAIL b2b grant%0d: got %b, expected req%0d", grants, reqReady, expWin);
        end
        lastGrant = expWin;
        grants++;
        if (expWin == 0) rem0--; else rem1--;
      end
    end
    @(negedge clk);
    reqValid = 2'b00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #2;
      if (doneCount - doneBase >= 3 && busy === 1'b0) break;
    end
    checks++;
    if (grants != 3) begin failures++; $display("[TB] FAIL b2b grants: got %0d, expected 3", grants); end
    checks++;
    if (doneCount - doneBase != 3) begin failures++; $display("[TB] FAIL b2b dones: got %0d, expected 3", doneCount - doneBase); end
    checks++;
    if (bothReady - bothBase != 0) begin failures++; $display("[TB] FAIL b2b readyBoth: got %0d cycles, expected 0", bothReady - bothBase); end
  endtask

  task automatic test_zero_steps();
    runOne("zero_steps", 0, 1'b0, 1'b0, 0, 0, 10'h2A7);
    runOne("zero_steps_clr", 1, 1'b1, 1'b1, 0, 0, 10'h0F0);
  endtask

  task automatic test_abort();
    runOne("abort_run2", 0, 1'b1, 1'b0, 10, 2, 10'h100);
    runOne("abort_clr_run3", 1, 1'b0, 1'b1, 10, 3, 10'h3FF);
  endtask

  task automatic test_mid_run_reset();
    int doneBase;
    bit got;
    @(negedge clk);
    loadVal = '0;
    loadEn  = 1'b1;
    @(negedge clk);
    loadEn = 1'b0;
    reqSteps[STEP_W-1:0] = 10'd10;
    reqDir[0] = 1'b0;
    reqClr[0] = 1'b0;
    expDir = 1'b0;
    reqValid = 2'b01;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin failures++; $display("[TB] FAIL rstRun accept: got %b, expected 01", reqReady); end
    @(negedge clk);
    reqValid = 2'b00;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (cntEn !== 1'b1) begin failures++; $display("[TB] FAIL rstRun running: cntEn got %0d, expected 1", cntEn); end
    doneBase = doneCount;
    rstN = 1'b0;
    #1;
    checks++;
    if (cntEn !== 1'b0 || busy !== 1'b0 || doneValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstRun async: en/busy/done got %0d/%0d/%0d, expected 0/0/0", cntEn, busy, doneValid);
    end
    lastGrant = 1;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (doneCount != doneBase) begin failures++; $display("[TB] FAIL rstRun dropped: got %0d done pulses, expected 0", doneCount - doneBase); end
    reqSteps = {10'd1, 10'd1};
    reqDir = 2'b00;
    reqClr = 2'b00;
    @(negedge clk);
    reqValid = 2'b11;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin failures++; $display("[TB] FAIL rstRun tie: got %b, expected 01", reqReady); end
    lastGrant = 0;
    @(negedge clk);
    reqValid = 2'b10;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (reqReady === 2'b10) begin got = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin failures++; $display("[TB] FAIL rstRun req1: got no grant, expected 10"); end
    lastGrant = 1;
    @(negedge clk);
    reqValid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #2;
      if (busy === 1'b0) break;
    end
  endtask

  task automatic test_random();
    int id, steps, abortAt;
    logic dir, clr;
    logic [CNT_W-1:0] start;
    for (int r = 0; r < 8; r++) begin
      id    = $urandom_range(0, 1);
      dir   = 1'($urandom_range(0, 1));
      clr   = 1'($urandom_range(0, 1));
      steps = $urandom_range(0, 12);
      start = CNT_W'($urandom);
      abortAt = 0;
      if (steps >= 2 && $urandom_range(0, 3) == 0) abortAt = $urandom_range(1, steps);
      runOne($sformatf("random%0d", r), id, dir, clr, steps, abortAt, start);
    end
  endtask

  task automatic test_max_steps();
    runOne("max_steps", 1, 1'b0, 1'b0, 1023, 0, 10'h005);
  endtask

  initial begin
    rstN     = 1'b0;
    reqValid = 2'b00;
    reqDir   = 2'b00;
    reqClr   = 2'b00;
    reqSteps = '0;
    abortIn  = 1'b0;
    loadEn   = 1'b0;
    loadVal  = '0;
    $display("[TB] starting counter_run_sched bench");
    test_reset();
    test_clear_runs();
    test_back_to_back();
    test_zero_steps();
    test_abort();
    test_mid_run_reset();
    test_random();
    test_max_steps();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
